// File: rtl/gate_table_sequencer_pkg.sv
// rtl/gate_table_sequencer_pkg.sv - shared state encoding and golden truth constants
package gate_table_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bit m is the expected gate output at minterm m, with a = MSB of the minterm.
  localparam logic [3:0] TRUTH_F_AND        = 4'b1000;
  localparam logic [3:0] TRUTH_F_OR         = 4'b1110;
  localparam logic [3:0] TRUTH_F_NAND       = 4'b0111;
  localparam logic [3:0] TRUTH_F_NOR        = 4'b0001;
  localparam logic [3:0] TRUTH_F_XOR        = 4'b0110;
  localparam logic [3:0] TRUTH_F_NOT_A_OR_B = 4'b1011;

endpackage

// File: rtl/gate_table_sequencer_settle_timer.sv
// rtl/gate_table_sequencer_settle_timer.sv - loadable down-counter with zero flag
module gate_table_sequencer_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/gate_table_sequencer.sv
// rtl/gate_table_sequencer.sv - sweeps all minterms into two gate units and checks them against a truth table
module gate_table_sequencer
  import gate_table_sequencer_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter int                SETTLE = 1,
  parameter logic [2**N_IN-1:0] TRUTH = TRUTH_F_NOT_A_OR_B
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [N_IN-1:0]     x_out,
  input  logic                y_struct,
  input  logic                y_expr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  err_mask,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     cur_minterm
);

  localparam int                NM     = 2**N_IN;
  localparam int                ERR_W  = N_IN + 1;
  localparam int                CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0]   LAST_M = N_IN'(NM - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [N_IN-1:0]   m_q, m_d;
  logic [NM-1:0]     mask_q, mask_d;
  logic [ERR_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              timer_zero;
  logic              m_fail;

  gate_table_sequencer_settle_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == ST_DRIVE),
    .value_i (CW'(SETTLE - 1)),
    .dec_i   (state_q == ST_WAIT),
    .zero_o  (timer_zero)
  );

  // A minterm where both units disagree with the table still counts as one failure.
  assign m_fail = (y_struct != TRUTH[m_q]) | (y_expr != TRUTH[m_q]);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = '0;
          mask_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        x_d     = m_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (m_fail) begin
          mask_d[m_q] = 1'b1;
          cnt_d       = cnt_q + ERR_W'(1);
        end
        if (m_q == LAST_M) begin
          state_d = ST_DONE;
        end else begin
          m_d     = m_q + N_IN'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        pass_d  = (cnt_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      m_q     <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out       = x_q;
  assign cur_minterm = m_q;
  assign err_mask    = mask_q;
  assign err_count   = cnt_q;
  assign pass        = pass_q;
  assign busy        = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done        = (state_q == ST_DONE);

endmodule
